// File: rtl/serial_comparator_pkg.sv
// Shared types and constants for the serial magnitude comparator and its nibble datapath.
// Result-flag indices match the bit positions of the four_bit_comparator C bus.
package serial_comparator_pkg;

    localparam int NIBBLE_WIDTH = 4;

    localparam int EQ = 0;
    localparam int GT = 1;
    localparam int LT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/four_bit_comparator.sv
// Purpose: combinational magnitude compare of two nibbles, one-hot C bus {LT,GT,EQ}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller owns all flow control.
module four_bit_comparator
    import serial_comparator_pkg::*;
(
    input  logic [NIBBLE_WIDTH-1:0] a,
    input  logic [NIBBLE_WIDTH-1:0] b,
    output logic [2:0]              c
);

    always_comb begin
        c     = '0;
        c[EQ] = (a == b);
        c[GT] = (a > b);
        c[LT] = (a < b);
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Purpose: compares two DATA_WIDTH operands one nibble per cycle, MSB first, exiting at the first difference.
// Latency: k+1 cycles from accept to out_valid_o, k = 1-based index of first differing nibble (NIBBLES if equal).
// Backpressure: one operation in flight; in_ready_o low until the result is taken; out_ready_i low holds DONE.
// Optional: SERIAL_COMPARATOR_SIGNED_EN selects two's-complement compare (sign decided in the first cycle).
module serial_magnitude_comparator
    import serial_comparator_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH / 4) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  aeqb_o,
    output logic                  agtb_o,
    output logic                  altb_o,
    output logic [CNT_WIDTH-1:0]  cycles_o
);

    localparam int NIBBLES = DATA_WIDTH / NIBBLE_WIDTH;

    if ((DATA_WIDTH % NIBBLE_WIDTH) != 0 || DATA_WIDTH < NIBBLE_WIDTH) begin : g_bad_width
        $error("serial_magnitude_comparator: DATA_WIDTH must be a positive multiple of 4");
    end

    state_t                  state;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [CNT_WIDTH-1:0]    idx;
    logic [NIBBLE_WIDTH-1:0] nib_a;
    logic [NIBBLE_WIDTH-1:0] nib_b;
    logic [2:0]              cmp_c;
    logic                    dec_gt;
    logic                    dec_lt;

    assign nib_a = a_q[int'(idx) * NIBBLE_WIDTH +: NIBBLE_WIDTH];
    assign nib_b = b_q[int'(idx) * NIBBLE_WIDTH +: NIBBLE_WIDTH];

    four_bit_comparator u_cmp (
        .a (nib_a),
        .b (nib_b),
        .c (cmp_c)
    );

`ifdef SERIAL_COMPARATOR_SIGNED_EN
    // First compare cycle with differing sign bits: the sign alone decides.
    logic sign_diff;
    assign sign_diff = (cycles_o == '0) && (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]);
    assign dec_gt    = sign_diff ? b_q[DATA_WIDTH-1] : cmp_c[GT];
    assign dec_lt    = sign_diff ? a_q[DATA_WIDTH-1] : cmp_c[LT];
`else
    assign dec_gt    = cmp_c[GT];
    assign dec_lt    = cmp_c[LT];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            aeqb_o      <= 1'b0;
            agtb_o      <= 1'b0;
            altb_o      <= 1'b0;
            cycles_o    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            idx         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q        <= a_i;
                        b_q        <= b_i;
                        idx        <= CNT_WIDTH'(NIBBLES - 1);
                        cycles_o   <= '0;
                        in_ready_o <= 1'b0;
                        state      <= COMPARE;
                    end
                end
                COMPARE: begin
                    cycles_o <= cycles_o + CNT_WIDTH'(1);
                    if (dec_gt || dec_lt) begin
                        agtb_o      <= dec_gt;
                        altb_o      <= dec_lt;
                        aeqb_o      <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end else if (idx == '0) begin
                        aeqb_o      <= cmp_c[EQ];
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx - CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    // in_ready_o is registered, so it rises in the IDLE cycle after the handshake.
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        aeqb_o      <= 1'b0;
                        agtb_o      <= 1'b0;
                        altb_o      <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
